// File: rtl/vram_arb_if.sv
// rtl/vram_arb_if.sv - display read port and host command port of the VRAM arbiter
interface vram_arb_if #(
  parameter int AW = 13,
  parameter int DW = 8
);
  logic          tft_rdreq;
  logic [AW-1:0] tft_raddr;
  logic          tft_rdack;
  logic [DW-1:0] tft_rdata;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_busy;
  logic          host_ack;
  logic [DW-1:0] host_rdata;

  modport master (
    output tft_rdreq, tft_raddr, host_req, host_we, host_addr, host_wdata,
    input  tft_rdack, tft_rdata, host_busy, host_ack, host_rdata
  );

  modport slave (
    input  tft_rdreq, tft_raddr, host_req, host_we, host_addr, host_wdata,
    output tft_rdack, tft_rdata, host_busy, host_ack, host_rdata
  );
endinterface

// File: rtl/vram_arb.sv
// rtl/vram_arb.sv - single-port frame RAM arbiter: display reads win, host commands fill idle cycles
module vram_arb #(
  parameter int            AW        = 13,
  parameter int            DW        = 8,
  parameter logic [AW-1:0] VRAM_SIZE = 13'h12C0
) (
  input  logic          clk,
  input  logic          rst_x,
  vram_arb_if.slave     bus,
  input  logic          cnt_clr,
  output logic [7:0]    conflict_cnt,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PEND  = 2'd1;
  localparam logic [1:0] RDCAP = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          cmd_in_range;
  logic          access_cycle;
  logic          conflict;

  assign cmd_in_range = (cmd_addr < VRAM_SIZE);
  assign conflict     = (state == PEND) && bus.tft_rdreq;
  assign access_cycle = (state == PEND) && !bus.tft_rdreq;

  assign bus.tft_rdack = bus.tft_rdreq;
  assign bus.tft_rdata = ram_rdata;
  assign bus.host_busy = (state != IDLE);
  assign bus.host_ack  = (state == DONE);

  // Display owns the port whenever it asks; the host only gets the cycle otherwise.
  always_comb begin
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (bus.tft_rdreq) begin
      ram_cs   = 1'b1;
      ram_addr = bus.tft_raddr;
    end else if (access_cycle && cmd_in_range) begin
      ram_cs    = 1'b1;
      ram_we    = cmd_we;
      ram_addr  = cmd_addr;
      ram_wdata = cmd_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state          <= IDLE;
      cmd_we         <= 1'b0;
      cmd_addr       <= '0;
      cmd_wdata      <= '0;
      bus.host_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.host_req) begin
            cmd_we    <= bus.host_we;
            cmd_addr  <= bus.host_addr;
            cmd_wdata <= bus.host_wdata;
            state     <= PEND;
          end
        end
        PEND: begin
          if (access_cycle) state <= cmd_we ? DONE : RDCAP;
        end
        RDCAP: begin
          // Out-of-range reads never selected the RAM, so ram_rdata is stale here.
          bus.host_rdata <= cmd_in_range ? ram_rdata : '0;
          state          <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      conflict_cnt <= 8'h00;
    end else if (cnt_clr) begin
      conflict_cnt <= 8'h00;
    end else if (conflict && (conflict_cnt != 8'hFF)) begin
      conflict_cnt <= conflict_cnt + 8'h01;
    end
  end
endmodule

// File: tb/tb_vram_arb.sv
// tb/tb_vram_arb.sv - scoreboard bench for vram_arb with a behavioural frame RAM
module tb_vram_arb;
  localparam int AW = 13;
  localparam int DW = 8;
  localparam logic [AW-1:0] VSIZE = 13'h12C0;

  logic          clk;
  logic          rst_x;
  logic          cnt_clr;
  logic [7:0]    conflict_cnt;
  logic          ram_cs;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  vram_arb_if #(.AW(AW), .DW(DW)) bus ();

  vram_arb #(.AW(AW), .DW(DW), .VRAM_SIZE(VSIZE)) dut (
    .clk          (clk),
    .rst_x        (rst_x),
    .bus          (bus.slave),
    .cnt_clr      (cnt_clr),
    .conflict_cnt (conflict_cnt),
    .ram_cs       (ram_cs),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int host_cs_cnt = 0;

  logic [7:0] mem     [0:8191];
  logic [7:0] ref_mem [0:8191];

  typedef struct {
    logic       is_rd;
    logic [7:0] data;
    int         ack_cyc;
  } host_exp_t;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } tft_exp_t;

  host_exp_t sb[$];
  tft_exp_t  tft_sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_wdata;
        wr_cnt        <= wr_cnt + 1;
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  always @(negedge clk) begin
    host_exp_t h;
    tft_exp_t  t;
    if (bus.host_ack) begin
      if (sb.size() == 0) begin
        check("spurious_ack", {31'd0, bus.host_ack}, 32'd0);
      end else begin
        h = sb.pop_front();
        check("ack_cycle", cyc, h.ack_cyc);
        if (h.is_rd) check("host_rdata", {24'd0, bus.host_rdata}, {24'd0, h.data});
      end
    end
    if (tft_sb.size() != 0 && tft_sb[0].cyc == cyc) begin
      t = tft_sb.pop_front();
      check("tft_rdata", {24'd0, bus.tft_rdata}, {24'd0, t.data});
    end
    if (bus.tft_rdreq) begin
      check("tft_rdack", {31'd0, bus.tft_rdack}, 32'd1);
      t.cyc  = cyc + 1;
      t.data = ref_mem[bus.tft_raddr];
      tft_sb.push_back(t);
    end
    if (ram_cs && !bus.tft_rdreq) host_cs_cnt <= host_cs_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives an accepted command for one cycle; returns one cycle later (R+1).
  task automatic host_cmd(input logic we, input logic [AW-1:0] addr, input logic [7:0] wdata,
                          input int lat);
    host_exp_t h;
    bus.host_req   = 1'b1;
    bus.host_we    = we;
    bus.host_addr  = addr;
    bus.host_wdata = wdata;
    h.is_rd   = !we;
    h.data    = (addr < VSIZE) ? ref_mem[addr] : 8'h00;
    h.ack_cyc = cyc + lat;
    if (we && addr < VSIZE) ref_mem[addr] = wdata;
    sb.push_back(h);
    tick();
    bus.host_req = 1'b0;
  endtask

  task automatic host_drop(input logic [AW-1:0] addr, input logic [7:0] wdata);
    bus.host_req   = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_addr  = addr;
    bus.host_wdata = wdata;
    tick();
    bus.host_req = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      check("ack_timeout", sb.size(), 0);
      sb.delete();
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0;
    int cs0;
    for (int i = 0; i < 8192; i++) begin
      mem[i]     = 8'(i) ^ 8'h3C;
      ref_mem[i] = 8'(i) ^ 8'h3C;
    end
    rst_x          = 1'b0;
    cnt_clr        = 1'b0;
    bus.tft_rdreq  = 1'b0;
    bus.tft_raddr  = '0;
    bus.host_req   = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    repeat (3) tick();
    rst_x = 1'b1;
    @(negedge clk);
    check("rst_busy", {31'd0, bus.host_busy}, 32'd0);
    check("rst_ack", {31'd0, bus.host_ack}, 32'd0);
    check("rst_rdata", {24'd0, bus.host_rdata}, 32'd0);
    check("rst_cnt", {24'd0, conflict_cnt}, 32'd0);
    check("rst_ram_cs", {31'd0, ram_cs}, 32'd0);

    // Reset while a write is stuck in PEND behind display traffic.
    tick();
    wr0 = wr_cnt;
    bus.tft_rdreq = 1'b1;
    bus.tft_raddr = 13'h0100;
    host_drop(13'h0020, 8'h77);
    tick();
    rst_x = 1'b0;
    tick();
    rst_x = 1'b1;
    bus.tft_rdreq = 1'b0;
    repeat (5) tick();
    check("abort_busy", {31'd0, bus.host_busy}, 32'd0);
    check("abort_cnt", {24'd0, conflict_cnt}, 32'd0);
    check("abort_wr_cnt", wr_cnt - wr0, 0);
    check("abort_mem", {24'd0, mem[13'h0020]}, {24'd0, ref_mem[13'h0020]});

    // Plain write then read-back.
    host_cmd(1'b1, 13'h0010, 8'hA5, 2);
    @(negedge clk);
    check("wr_cs", {31'd0, ram_cs}, 32'd1);
    check("wr_we", {31'd0, ram_we}, 32'd1);
    check("wr_addr", {19'd0, ram_addr}, 32'h10);
    wait_done();
    host_cmd(1'b0, 13'h0010, 8'h00, 3);
    wait_done();
    check("rd_a5", {24'd0, bus.host_rdata}, 32'hA5);

    // Three display reads defer a host read.
    host_cmd(1'b0, 13'h0030, 8'h00, 6);
    for (int i = 0; i < 3; i++) begin
      bus.tft_rdreq = 1'b1;
      bus.tft_raddr = 13'h0200 + 13'(i);
      tick();
    end
    bus.tft_rdreq = 1'b0;
    @(negedge clk);
    check("cf_cs", {31'd0, ram_cs}, 32'd1);
    check("cf_we", {31'd0, ram_we}, 32'd0);
    check("cf_addr", {19'd0, ram_addr}, 32'h30);
    wait_done();
    check("cf_cnt", {24'd0, conflict_cnt}, 32'd3);

    // Last valid byte, then first invalid byte.
    host_cmd(1'b1, 13'h12BF, 8'h5A, 2);
    wait_done();
    host_cmd(1'b0, 13'h12BF, 8'h00, 3);
    wait_done();
    check("edge_rd", {24'd0, bus.host_rdata}, 32'h5A);
    cs0 = host_cs_cnt;
    wr0 = wr_cnt;
    host_cmd(1'b1, 13'h12C0, 8'h55, 2);
    wait_done();
    host_cmd(1'b0, 13'h12C0, 8'h00, 3);
    wait_done();
    check("oor_cs", host_cs_cnt - cs0, 0);
    check("oor_wr", wr_cnt - wr0, 0);
    check("oor_rdata", {24'd0, bus.host_rdata}, 32'd0);

    // Commands while busy are dropped.
    host_cmd(1'b1, 13'h0040, 8'h11, 2);
    host_drop(13'h0041, 8'h22);
    host_drop(13'h0040, 8'h33);
    wait_done();
    check("drop_mem40", {24'd0, mem[13'h0040]}, 32'h11);
    check("drop_mem41", {24'd0, mem[13'h0041]}, {24'd0, ref_mem[13'h0041]});
    host_cmd(1'b0, 13'h0041, 8'h00, 3);
    wait_done();

    // Saturation, then clear colliding with a conflict cycle.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    host_cmd(1'b0, 13'h0050, 8'h00, 304);
    for (int i = 0; i < 301; i++) begin
      bus.tft_rdreq = 1'b1;
      bus.tft_raddr = 13'h0300 + 13'(i);
      cnt_clr = (i == 300);
      @(negedge clk);
      if (i == 300) check("sat_cnt", {24'd0, conflict_cnt}, 32'hFF);
      tick();
    end
    bus.tft_rdreq = 1'b0;
    cnt_clr = 1'b0;
    @(negedge clk);
    check("clr_cnt", {24'd0, conflict_cnt}, 32'd0);
    wait_done();
    check("final_busy", {31'd0, bus.host_busy}, 32'd0);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vram_arb.md
# vram_arb

Single-port display-RAM arbiter between the TFT timing generator's read port and the host (MCU-side) access port. Display reads are real-time: they are acknowledged in the same cycle and never stall. Host reads and writes are posted as single-cycle commands and executed in the next RAM cycle not used by the display. Sits between `tft_tg`, the host register/command decoder, and the 4800-byte synchronous frame RAM.

## Interface
Parameters:
- AW, 13, RAM address width
- DW, 8, RAM data width
- VRAM_SIZE, 13'h12C0, number of valid bytes; host addresses >= VRAM_SIZE are out of range

Ports:
- clk  in  1  clock
- rst_x  in  1  asynchronous reset, active low
- tft_rdreq  in  1  display read request, single-cycle pulse
- tft_raddr  in  AW  display read address, valid with tft_rdreq
- tft_rdack  out  1  display read acknowledge, combinational
- tft_rdata  out  DW  display read data, valid in the cycle after tft_rdack
- host_req  in  1  host command strobe, single-cycle pulse
- host_we  in  1  1 = write, 0 = read; sampled with host_req
- host_addr  in  AW  host address; sampled with host_req
- host_wdata  in  DW  host write data; sampled with host_req
- host_busy  out  1  command in progress; host_req is ignored while high
- host_ack  out  1  command complete, single-cycle pulse
- host_rdata  out  DW  host read data, registered, held until the next read completes
- cnt_clr  in  1  synchronous clear of conflict_cnt
- conflict_cnt  out  8  saturating count of host cycles deferred by the display
- ram_cs  out  1  RAM select
- ram_we  out  1  RAM write enable
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data, valid one cycle after a read select

## Operation
- Display path is purely combinational.
  - tft_rdack = tft_rdreq.
  - When tft_rdreq = 1: ram_cs = 1, ram_we = 0, ram_addr = tft_raddr.
  - tft_rdata = ram_rdata.
- Host command registers (we, addr, wdata) load when host_req = 1 and state = IDLE.
  - host_req in any other state is dropped; no side effects.
- FSM states:
  - IDLE: on host_req, go to PEND.
  - PEND: if tft_rdreq = 1, stay in PEND and increment conflict_cnt. Otherwise perform the access cycle (A).
    - Write: go to DONE.
    - Read: go to RDCAP.
  - RDCAP: host_rdata <= (addr in range) ? ram_rdata : 8'h00. Go to DONE.
  - DONE: host_ack = 1. Go to IDLE.
- Access cycle A, in-range address: ram_cs = 1, ram_we = host_we, ram_addr = cmd addr, ram_wdata = cmd wdata.
- Access cycle A, out-of-range address: ram_cs = 0. The write is discarded, and the read returns 8'h00. Ack timing is unchanged.
- host_busy = (state != IDLE).
- conflict_cnt:
  - Saturates at 8'hFF.
  - cnt_clr has priority over an increment in the same cycle.
- Idle RAM outputs (no display request, not in cycle A): ram_cs = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0.

## Timing
- Reset values:
  - state = IDLE.
  - host_busy = 0, host_ack = 0, host_rdata = 8'h00, conflict_cnt = 8'h00.
  - ram_* follow the display path only.
- Reset asserted mid-command aborts the command: no ack, and no RAM write after reset.
- Display read: ack in cycle N, data at tft_rdata in N+1. Zero added latency.
- Host command accepted in cycle R:
  - PEND at R+1.
  - With no conflict: A = R+1.
  - Write: ack at A+1, i.e. latency 2.
  - Read: capture at A+1, ack at A+2, i.e. latency 3. host_rdata is valid from A+2.
- Each tft_rdreq coinciding with PEND delays A by one cycle.
- tft_rdreq during RDCAP or DONE never conflicts with the host.
  - RDCAP samples ram_rdata produced by cycle A's host read.
  - A display read issued in RDCAP returns data in DONE, on tft_rdata only.
- Earliest back-to-back host command: host_req in the cycle after host_ack.

## Test plan
- Reset: hold rst_x low mid-PEND, then release. Required: host_busy = 0, no host_ack, conflict_cnt = 0, no RAM write occurs.
- Host write, addr 13'h0010, data 8'hA5, no display traffic. Required: ram_cs = 1 and ram_we = 1 at R+1, host_ack at R+2. A following read of 13'h0010 acks at R'+3 with host_rdata = 8'hA5.
- Conflict: host read issued while tft_rdreq is high for 3 consecutive cycles starting at R+1. Required:
  - tft_rdack matches every request.
  - Host access at R+4, host_ack at R+6.
  - conflict_cnt = 3.
- Out of range: write 8'h55 to 13'h12C0, then read 13'h12C0. Required:
  - ram_cs stays low for both.
  - Acks arrive at normal latency.
  - host_rdata = 8'h00.
- Busy drop: host_req pulses at R+1 and R+2 after an accepted write at R. Required: only one ack, and memory contains only the first command's data.
- Saturation: force 300 deferred cycles. Required: conflict_cnt = 8'hFF. Assert cnt_clr together with a conflict cycle. Required: conflict_cnt = 8'h00.
